// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for three execution units onto a single register-file write port,
// plus a pending-destination scoreboard. Define WB_RR_ARB_EN for round-robin, else fixed priority.
module regfile_wb_arbiter #(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [2:0]      wb_valid,
  input  logic [4:0]      wb_rd0,
  input  logic [4:0]      wb_rd1,
  input  logic [4:0]      wb_rd2,
  input  logic [XLEN-1:0] wb_data0,
  input  logic [XLEN-1:0] wb_data1,
  input  logic [XLEN-1:0] wb_data2,
  output logic [2:0]      wb_ready,
  output logic [4:0]      DR,
  output logic [XLEN-1:0] WB_DATA,
  output logic            ST_REG,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic [4:0]      SR1,
  input  logic [4:0]      SR2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            flush
);

  logic [2:0]      grant;
  logic            transfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     busy;
  logic [31:0]     busy_next;
  logic            issue_fire;

`ifdef WB_RR_ARB_EN
  logic [1:0] rr_ptr;

  // Search order is ptr, ptr+1, ptr+2 (mod 3); first valid requester wins.
  function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] p);
    logic [2:0] pick;
    logic [2:0] s;
    pick = '0;
    for (int k = 0; k < 3; k++) begin
      s = {1'b0, p} + 3'(k);
      if (s >= 3'd3) s = s - 3'd3;
      if (pick == 3'b000 && v[s[1:0]]) pick[s[1:0]] = 1'b1;
    end
    return pick;
  endfunction

  always_comb grant = rr_pick(wb_valid, rr_ptr);

  always_ff @(posedge CLK) begin
    if (reset)
      rr_ptr <= 2'd0;
    else if (wb_ready[0])
      rr_ptr <= 2'd1;
    else if (wb_ready[1])
      rr_ptr <= 2'd2;
    else if (wb_ready[2])
      rr_ptr <= 2'd0;
  end
`else
  always_comb begin
    if (wb_valid[0])      grant = 3'b001;
    else if (wb_valid[1]) grant = 3'b010;
    else if (wb_valid[2]) grant = 3'b100;
    else                  grant = 3'b000;
  end
`endif

  assign wb_ready = reset ? 3'b000 : grant;
  assign transfer = |(wb_valid & wb_ready);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_rd   = wb_rd0;
    sel_data = wb_data0;
    if (wb_ready[1]) begin
      sel_rd   = wb_rd1;
      sel_data = wb_data1;
    end else if (wb_ready[2]) begin
      sel_rd   = wb_rd2;
      sel_data = wb_data2;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) begin
      DR      <= '0;
      WB_DATA <= '0;
      ST_REG  <= 1'b0;
    end else if (transfer) begin
      DR      <= sel_rd;
      WB_DATA <= sel_data;
      ST_REG  <= (sel_rd != 5'd0);
    end else begin
      ST_REG  <= 1'b0;
    end
  end

  assign issue_ready = !reset && (issue_rd == 5'd0 || !busy[issue_rd]);
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);

  // Clear first, then set, so a same-cycle set on the retiring register wins.
  always_comb begin
    busy_next = busy;
    if (ST_REG)     busy_next[DR]       = 1'b0;
    if (issue_fire) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: the scoreboard is a 32-bit flop vector, not a RAM, so it can and must be reset.
  always_ff @(posedge CLK) begin
    if (reset || flush)
      busy <= '0;
    else
      busy <= busy_next;
  end

  assign rs1_busy = busy[SR1];
  assign rs2_busy = busy[SR2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: reset-state vector table, directed
// multi-cycle sequences, then randomized traffic against a scoreboard-style model.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 64;

  logic            CLK;
  logic            reset;
  logic [2:0]      wb_valid;
  logic [4:0]      wb_rd0, wb_rd1, wb_rd2;
  logic [XLEN-1:0] wb_data0, wb_data1, wb_data2;
  logic [2:0]      wb_ready;
  logic [4:0]      DR;
  logic [XLEN-1:0] WB_DATA;
  logic            ST_REG;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic [4:0]      SR1, SR2;
  logic            rs1_busy, rs2_busy;
  logic            flush;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.XLEN(XLEN)) dut (
    .CLK(CLK), .reset(reset),
    .wb_valid(wb_valid),
    .wb_rd0(wb_rd0), .wb_rd1(wb_rd1), .wb_rd2(wb_rd2),
    .wb_data0(wb_data0), .wb_data1(wb_data1), .wb_data2(wb_data2),
    .wb_ready(wb_ready),
    .DR(DR), .WB_DATA(WB_DATA), .ST_REG(ST_REG),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .SR1(SR1), .SR2(SR2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .flush(flush)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0;
    wb_valid = 3'b000;
    wb_rd0 = '0; wb_rd1 = '0; wb_rd2 = '0;
    wb_data0 = '0; wb_data1 = '0; wb_data2 = '0;
    issue_valid = 1'b0; issue_rd = '0;
    SR1 = '0; SR2 = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Reference arbitration: fixed priority, or round-robin starting at ptr.
  function automatic logic [2:0] exp_grant(input logic [2:0] v, input int ptr);
    logic [2:0] g;
    g = '0;
`ifdef WB_RR_ARB_EN
    for (int k = 0; k < 3; k++)
      if (g == 3'b000 && v[(ptr + k) % 3]) g[(ptr + k) % 3] = 1'b1;
`else
    for (int i = 0; i < 3; i++)
      if (g == 3'b000 && v[i]) g[i] = 1'b1;
    if (ptr < 0) g = '0;
`endif
    return g;
  endfunction

  typedef struct {
    logic [2:0] valid;
    logic [4:0] ird;
    logic [2:0] exp_ready;
    logic       exp_iready;
  } vec_t;

  vec_t vt[8];

  // Randomized-phase model state
  bit              m_busy[32];
  int              m_ptr;
  logic            m_st;
  logic [4:0]      m_dr;
  logic [XLEN-1:0] m_data;
  bit              rq_v[3];
  logic [4:0]      rq_rd[3];
  logic [XLEN-1:0] rq_d[3];

  initial begin
    logic [2:0] rr_order[4];
    logic [4:0] dr_order[4];

    vt[0] = '{3'b000, 5'd0,  3'b000, 1'b1};
    vt[1] = '{3'b001, 5'd1,  3'b001, 1'b1};
    vt[2] = '{3'b010, 5'd2,  3'b010, 1'b1};
    vt[3] = '{3'b011, 5'd7,  3'b001, 1'b1};
    vt[4] = '{3'b100, 5'd31, 3'b100, 1'b1};
    vt[5] = '{3'b101, 5'd5,  3'b001, 1'b1};
    vt[6] = '{3'b110, 5'd9,  3'b010, 1'b1};
    vt[7] = '{3'b111, 5'd3,  3'b001, 1'b1};

    idle();
    reset = 1'b1;
    wb_valid = 3'b111;
    issue_rd = 5'd0;
    #2;
    check("ready_in_reset", 64'(wb_ready), 64'd0);
    check("issue_ready_in_reset", 64'(issue_ready), 64'd0);
    tick();
    tick();
    check("rst_st_reg", 64'(ST_REG), 64'd0);
    check("rst_dr", 64'(DR), 64'd0);
    check("rst_wb_data", WB_DATA, 64'd0);
    wb_valid = 3'b000;
    reset = 1'b0;

    // Combinational vectors from the reset state (pointer at ALU, scoreboard empty).
    for (int i = 0; i < 8; i++) begin
      wb_valid = vt[i].valid;
      issue_rd = vt[i].ird;
      SR1 = vt[i].ird;
      SR2 = 5'(31 - i);
      #1;
      check($sformatf("vec%0d_ready", i), 64'(wb_ready), 64'(vt[i].exp_ready));
      check($sformatf("vec%0d_issue_ready", i), 64'(issue_ready), 64'(vt[i].exp_iready));
      check($sformatf("vec%0d_rs1", i), 64'(rs1_busy), 64'd0);
      check($sformatf("vec%0d_rs2", i), 64'(rs2_busy), 64'd0);
    end
    idle();
    #1;

    // Single write with scoreboard set and clear.
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1 check("sw_issue_ready", 64'(issue_ready), 64'd1);
    tick();
    issue_valid = 1'b0; SR1 = 5'd5;
    wb_valid = 3'b001; wb_rd0 = 5'd5; wb_data0 = 64'hDEAD;
    #1 check("sw_ready", 64'(wb_ready), 64'b001);
    check("sw_busy_set", 64'(rs1_busy), 64'd1);
    tick();
    wb_valid = 3'b000;
    #1 check("sw_st", 64'(ST_REG), 64'd1);
    check("sw_dr", 64'(DR), 64'd5);
    check("sw_data", WB_DATA, 64'hDEAD);
    tick();
    check("sw_st_drop", 64'(ST_REG), 64'd0);
    check("sw_dr_hold", 64'(DR), 64'd5);
    check("sw_busy_clear", 64'(rs1_busy), 64'd0);

    // Contention: all three requesters continuously valid.
    do_reset();
`ifdef WB_RR_ARB_EN
    rr_order = '{3'b001, 3'b010, 3'b100, 3'b001};
    dr_order = '{5'd1, 5'd2, 5'd3, 5'd1};
`else
    rr_order = '{3'b001, 3'b001, 3'b001, 3'b001};
    dr_order = '{5'd1, 5'd1, 5'd1, 5'd1};
`endif
    wb_valid = 3'b111;
    wb_rd0 = 5'd1; wb_rd1 = 5'd2; wb_rd2 = 5'd3;
    wb_data0 = 64'hA1; wb_data1 = 64'hB2; wb_data2 = 64'hC3;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("cont%0d_ready", k), 64'(wb_ready), 64'(rr_order[k]));
      tick();
      check($sformatf("cont%0d_dr", k), 64'(DR), 64'(dr_order[k]));
      check($sformatf("cont%0d_st", k), 64'(ST_REG), 64'd1);
    end
    idle();

    // Writeback to x0 is accepted but never written.
    wb_valid = 3'b010; wb_rd1 = 5'd0; wb_data1 = 64'h1;
    #1 check("x0_ready", 64'(wb_ready), 64'b010);
    tick();
    wb_valid = 3'b000;
    #1 check("x0_st", 64'(ST_REG), 64'd0);
    tick();
    check("x0_st_after", 64'(ST_REG), 64'd0);

    // Same-cycle retire and re-issue of the same register.
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    wb_valid = 3'b001; wb_rd0 = 5'd7; wb_data0 = 64'h77;
    #1 check("waw_ready", 64'(wb_ready), 64'b001);
    tick();
    wb_valid = 3'b000;
    issue_valid = 1'b1; issue_rd = 5'd7; SR1 = 5'd7;
    #1 check("waw_st", 64'(ST_REG), 64'd1);
    check("waw_dr", 64'(DR), 64'd7);
    check("waw_issue_blocked", 64'(issue_ready), 64'd0);
    check("waw_busy_before", 64'(rs1_busy), 64'd1);
    tick();
    check("waw_issue_open", 64'(issue_ready), 64'd1);
    check("waw_busy_cleared", 64'(rs1_busy), 64'd0);
    tick();
    issue_valid = 1'b0;
    #1 check("waw_busy_reset", 64'(rs1_busy), 64'd1);

    // Flush with a write in flight; then set beats clear on the same register.
    do_reset();
    issue_valid = 1'b1;
    issue_rd = 5'd3; tick();
    issue_rd = 5'd4; tick();
    issue_rd = 5'd9; tick();
    issue_valid = 1'b0;
    SR1 = 5'd3; SR2 = 5'd9;
    wb_valid = 3'b100; wb_rd2 = 5'd4; wb_data2 = 64'h44; flush = 1'b1;
    #1 check("fl_ready", 64'(wb_ready), 64'b100);
    check("fl_busy3_pre", 64'(rs1_busy), 64'd1);
    check("fl_busy9_pre", 64'(rs2_busy), 64'd1);
    tick();
    flush = 1'b0; wb_valid = 3'b000;
    issue_valid = 1'b1; issue_rd = 5'd4;
    #1 check("fl_busy3", 64'(rs1_busy), 64'd0);
    check("fl_busy9", 64'(rs2_busy), 64'd0);
    check("fl_busy4_free", 64'(issue_ready), 64'd1);
    check("fl_st", 64'(ST_REG), 64'd1);
    check("fl_dr", 64'(DR), 64'd4);
    check("fl_data", WB_DATA, 64'h44);
    tick();
    issue_valid = 1'b0; SR1 = 5'd4;
    #1 check("set_wins", 64'(rs1_busy), 64'd1);

    // Reset in a grant cycle after the pointer has moved off ALU.
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd6;
    tick();
    issue_valid = 1'b0; issue_rd = 5'd0;
    wb_valid = 3'b010; wb_rd1 = 5'd8; wb_data1 = 64'h88;
    tick();
    wb_valid = 3'b101; wb_rd0 = 5'd10; wb_rd2 = 5'd11;
    wb_data0 = 64'h10; wb_data2 = 64'h11; reset = 1'b1;
    #1 check("rmt_ready", 64'(wb_ready), 64'd0);
    check("rmt_issue_ready", 64'(issue_ready), 64'd0);
    tick();
    reset = 1'b0; SR1 = 5'd6;
    wb_valid = 3'b111; wb_rd1 = 5'd12;
    #1 check("rmt_st", 64'(ST_REG), 64'd0);
    check("rmt_dr", 64'(DR), 64'd0);
    check("rmt_data", WB_DATA, 64'd0);
    check("rmt_busy", 64'(rs1_busy), 64'd0);
    check("rmt_ptr_alu", 64'(wb_ready), 64'b001);
    tick();
    wb_valid = 3'b000;
    #1 check("rmt_dr_after", 64'(DR), 64'd10);
    check("rmt_st_after", 64'(ST_REG), 64'd1);

    // Randomized traffic against the reference model.
    do_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_ptr = 0; m_st = 1'b0; m_dr = '0; m_data = '0;
    for (int i = 0; i < 3; i++) begin
      rq_v[i] = 1'b0; rq_rd[i] = '0; rq_d[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      logic       r, f, iv, eir;
      logic [4:0] ird, s1, s2;
      logic [2:0] eg;
      int         g;
      for (int i = 0; i < 3; i++)
        if (!rq_v[i] && $urandom_range(0, 1) == 1) begin
          rq_v[i]  = 1'b1;
          rq_rd[i] = 5'($urandom_range(0, 7));
          rq_d[i]  = {$urandom, $urandom};
        end
      r   = ($urandom_range(0, 39) == 0);
      f   = ($urandom_range(0, 11) == 0);
      iv  = ($urandom_range(0, 1) == 1);
      ird = 5'($urandom_range(0, 7));
      s1  = 5'($urandom_range(0, 7));
      s2  = 5'($urandom_range(0, 7));
      reset = r; flush = f; issue_valid = iv; issue_rd = ird; SR1 = s1; SR2 = s2;
      wb_valid = {rq_v[2], rq_v[1], rq_v[0]};
      wb_rd0 = rq_rd[0]; wb_rd1 = rq_rd[1]; wb_rd2 = rq_rd[2];
      wb_data0 = rq_d[0]; wb_data1 = rq_d[1]; wb_data2 = rq_d[2];
      #1;
      eg  = r ? 3'b000 : exp_grant(wb_valid, m_ptr);
      eir = !r && (ird == 5'd0 || !m_busy[ird]);
      check("rnd_ready", 64'(wb_ready), 64'(eg));
      check("rnd_issue_ready", 64'(issue_ready), 64'(eir));
      check("rnd_rs1", 64'(rs1_busy), 64'(m_busy[s1]));
      check("rnd_rs2", 64'(rs2_busy), 64'(m_busy[s2]));
      tick();
      if (r || f) begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
      end else begin
        if (m_st) m_busy[m_dr] = 1'b0;
        if (iv && eir && ird != 5'd0) m_busy[ird] = 1'b1;
      end
      g = -1;
      for (int i = 0; i < 3; i++) if (eg[i]) g = i;
      if (r) begin
        m_st = 1'b0; m_dr = '0; m_data = '0; m_ptr = 0;
      end else if (g >= 0) begin
        m_dr   = rq_rd[g];
        m_data = rq_d[g];
        m_st   = (rq_rd[g] != 5'd0);
        m_ptr  = (g + 1) % 3;
        rq_v[g] = 1'b0;
      end else begin
        m_st = 1'b0;
      end
      check("rnd_st", 64'(ST_REG), 64'(m_st));
      check("rnd_dr", 64'(DR), 64'(m_dr));
      check("rnd_data", WB_DATA, m_data);
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64: writeback data width, equal to the register file width.
REQ-002 SHALL have input CLK, 1 bit: clock; all state updates on posedge CLK.
REQ-003 SHALL have input reset, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have inputs wb_valid, 3 bits: per-requester writeback request; 0=ALU, 1=LSU, 2=MDU.
REQ-005 SHALL have inputs wb_rd0/wb_rd1/wb_rd2, 5 bits each: destination register per requester.
REQ-006 SHALL have inputs wb_data0/wb_data1/wb_data2, XLEN bits each: writeback data per requester.
REQ-007 SHALL have output wb_ready, 3 bits: one-hot grant; a transfer occurs when wb_valid[i] and wb_ready[i] are both high.
REQ-008 SHALL have outputs DR (5 bits), WB_DATA (XLEN bits) and ST_REG (1 bit): registered register-file write port.
REQ-009 SHALL have inputs issue_valid (1 bit) and issue_rd (5 bits): decode marks a destination as pending.
REQ-010 SHALL have output issue_ready, 1 bit: high when issue_rd==0 or busy[issue_rd]==0.
REQ-011 SHALL have inputs SR1 and SR2, 5 bits each, and outputs rs1_busy and rs2_busy, 1 bit each: hazard query.
REQ-012 SHALL have input flush, 1 bit: pipeline flush.

Function
REQ-013 SHALL assert at most one wb_ready bit per cycle, combinationally from wb_valid and arbiter state, and only for a requester whose wb_valid is high.
REQ-014 SHALL register an accepted transfer in cycle N so that DR/WB_DATA hold its rd/data in cycle N+1, with ST_REG=1 for exactly that cycle.
REQ-015 SHALL drive ST_REG=0 in any cycle following a cycle with no transfer; DR and WB_DATA then hold their last values.
REQ-016 SHALL accept a transfer with rd==0 but drive ST_REG=0 for it, so x0 is never written.
REQ-017 SHALL keep a 32-bit scoreboard busy[]; busy[0] is constant 0.
REQ-018 SHALL set busy[issue_rd] at posedge when issue_valid && issue_ready && issue_rd!=0.
REQ-019 SHALL clear busy[DR] at posedge when ST_REG==1.
REQ-020 SHALL let the set win when a set and a clear target the same register in the same cycle.
REQ-021 SHALL clear every busy bit at posedge when flush==1, overriding any simultaneous set or clear; an in-flight ST_REG still completes its write.
REQ-022 SHALL compute rs1_busy=busy[SR1] and rs2_busy=busy[SR2] combinationally; both are 0 when the source is register 0.
REQ-023 SHALL hold a requester that is not granted with no side effects; a requester holds valid, rd and data stable until it is granted.

Reset
REQ-024 SHALL, while reset==1 at posedge, clear busy[] to 0, ST_REG to 0, DR to 0, WB_DATA to 0 and the round-robin pointer to 0.
REQ-025 SHALL drive wb_ready=0 and issue_ready=0 while reset is high.
REQ-026 SHALL drop a transfer or issue coincident with reset, with no write performed.

Configuration
REQ-027 SHALL use macro WB_RR_ARB_EN to select the arbitration policy.
REQ-028 SHALL, with WB_RR_ARB_EN defined, arbitrate round-robin.
- Search starts at the pointer.
- After each accepted transfer, the pointer becomes (granted index + 1) mod 3.
- The pointer is unchanged in cycles with no transfer.
REQ-029 SHALL, without WB_RR_ARB_EN, use fixed priority ALU > LSU > MDU, with no pointer state.

Verification
REQ-030 Single write: issue rd=5, then ALU valid rd=5 data=0xDEAD -> wb_ready=001; next cycle DR=5, WB_DATA=0xDEAD, ST_REG=1; busy[5]=0 the cycle after.
REQ-031 Contention: all three valid continuously, distinct rd 1/2/3 -> RR grant order ALU, LSU, MDU, ALU; fixed priority grants ALU every cycle.
REQ-032 x0: LSU valid rd=0 data=0x1 -> wb_ready=010, ST_REG stays 0.
REQ-033 WAW/same-cycle: busy[7]=1; ST_REG clears 7 while issue rd=7 -> issue_ready=0, so no set; next cycle issue_ready=1, busy[7]=1 after issue.
REQ-034 Flush: busy[3,4,9]=1 plus a pending write to 4, flush=1 -> all busy 0 next cycle and ST_REG=1 for DR=4 still observed.
REQ-035 Reset mid-transfer: reset asserted in the grant cycle -> ST_REG=0, DR=0, busy all 0, and the RR pointer restarts at ALU.
